// File: rtl/memory_arbiter_pkg.sv
// Shared types for the two-master memory arbiter: FSM states and owner encoding.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic OWNER0 = 1'b0;
  localparam logic OWNER1 = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin chooser; on a tie the master not served last wins.
module rr_pick2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_valid,
  output logic o_winner
);

  assign o_valid  = i_req0 | i_req1;
  assign o_winner = (i_req0 && i_req1) ? ~i_last : i_req1;

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter/sequencer serialising two masters' read/write commands
// onto a single-port synchronous memory (IDLE -> ACCESS -> RESP per command).
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int width    = 8,
  parameter int addrSize = 8,
  parameter int size     = 100
) (
  input  logic                i_clk,
  input  logic                i_rstN,
  input  logic                i_req0,
  input  logic                i_req1,
  input  logic                i_write0,
  input  logic                i_write1,
  input  logic [addrSize-1:0] i_addr0,
  input  logic [addrSize-1:0] i_addr1,
  input  logic [width-1:0]    i_wrData0,
  input  logic [width-1:0]    i_wrData1,
  output logic                o_gnt0,
  output logic                o_gnt1,
  output logic                o_done0,
  output logic                o_done1,
  output logic [width-1:0]    o_rdData0,
  output logic [width-1:0]    o_rdData1,
  output logic                o_busy,
  output logic                o_memWrite,
  output logic [addrSize-1:0] o_memAddr,
  output logic [width-1:0]    o_memWrData,
  input  logic [width-1:0]    i_memRdData
);

  state_t              r_state, w_next;
  logic                r_last, r_owner, r_cmdWrite;
  logic [addrSize-1:0] r_cmdAddr;
  logic [width-1:0]    r_cmdWrData;
  logic                r_gnt0, r_gnt1, r_done0, r_done1, r_busy;
  logic [width-1:0]    r_rdData0, r_rdData1;
  logic                w_valid, w_winner, w_take, w_inRange;
  logic [width-1:0]    w_rdVal;

  rr_pick2 u_pick (
    .i_req0  (i_req0),
    .i_req1  (i_req1),
    .i_last  (r_last),
    .o_valid (w_valid),
    .o_winner(w_winner)
  );

  assign w_take    = (r_state == IDLE) && w_valid;
  assign w_inRange = (32'(r_cmdAddr) < size);
  assign w_rdVal   = w_inRange ? i_memRdData : '0;

  always_ff @(posedge i_clk) begin
    if (!i_rstN) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_valid) w_next = ACCESS;
      ACCESS:  w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_last      <= OWNER1;
      r_owner     <= OWNER0;
      r_cmdWrite  <= 1'b0;
      r_cmdAddr   <= '0;
      r_cmdWrData <= '0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_busy      <= 1'b0;
      r_rdData0   <= '0;
      r_rdData1   <= '0;
    end else begin
      r_gnt0  <= w_take && (w_winner == OWNER0);
      r_gnt1  <= w_take && (w_winner == OWNER1);
      r_done0 <= (r_state == RESP) && (r_owner == OWNER0);
      r_done1 <= (r_state == RESP) && (r_owner == OWNER1);
      r_busy  <= (w_next != IDLE);
      if (w_take) begin
        r_last      <= w_winner;
        r_owner     <= w_winner;
        r_cmdWrite  <= (w_winner == OWNER1) ? i_write1  : i_write0;
        r_cmdAddr   <= (w_winner == OWNER1) ? i_addr1   : i_addr0;
        r_cmdWrData <= (w_winner == OWNER1) ? i_wrData1 : i_wrData0;
      end
      if ((r_state == RESP) && !r_cmdWrite) begin
        if (r_owner == OWNER1) r_rdData1 <= w_rdVal;
        else                   r_rdData0 <= w_rdVal;
      end
    end
  end

  // Gated by rstN so a reset landing in ACCESS cancels the write at that same edge.
  assign o_memWrite  = i_rstN && (r_state == ACCESS) && r_cmdWrite && w_inRange;
  assign o_memAddr   = r_cmdAddr;
  assign o_memWrData = r_cmdWrData;
  assign o_gnt0      = r_gnt0;
  assign o_gnt1      = r_gnt1;
  assign o_done0     = r_done0;
  assign o_done1     = r_done1;
  assign o_busy      = r_busy;
  assign o_rdData0   = r_rdData0;
  assign o_rdData1   = r_rdData1;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (shadow memory, round-robin rule, fixed 3-cycle latency).
module tb_memory_arbiter;

  localparam int W = 8;
  localparam int A = 8;
  localparam int S = 100;

  logic         clk = 1'b0;
  logic         rstN = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0, write0 = 1'b0, write1 = 1'b0;
  logic [A-1:0] addr0 = '0, addr1 = '0;
  logic [W-1:0] wd0 = '0, wd1 = '0;
  logic         gnt0, gnt1, done0, done1, busy, memWrite;
  logic [W-1:0] rd0, rd1, memWrData, memRdData;
  logic [A-1:0] memAddr;

  logic [W-1:0] mem    [0:255];
  logic [W-1:0] shadow [0:255];
  logic         pre_en = 1'b0;
  logic [A-1:0] pre_addr = '0;
  logic [W-1:0] pre_data = '0;

  int errs = 0;
  int checks = 0;

  memory_arbiter #(.width(W), .addrSize(A), .size(S)) dut (
    .i_clk(clk), .i_rstN(rstN),
    .i_req0(req0), .i_req1(req1), .i_write0(write0), .i_write1(write1),
    .i_addr0(addr0), .i_addr1(addr1), .i_wrData0(wd0), .i_wrData1(wd1),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_done0(done0), .o_done1(done1),
    .o_rdData0(rd0), .o_rdData1(rd1), .o_busy(busy), .o_memWrite(memWrite),
    .o_memAddr(memAddr), .o_memWrData(memWrData), .i_memRdData(memRdData)
  );

  always #5 clk = ~clk;

  // Single-port memory with registered read; out-of-range reads return junk.
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (memWrite) mem[memAddr] <= memWrData;
    memRdData <= (int'(memAddr) < S) ? mem[memAddr] : 8'h5A;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [A-1:0] a, input logic [W-1:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    step();
    pre_en = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    req0 = 1'b1; req1 = 1'b1; write0 = 1'b1; write1 = 1'b1;
    addr0 = 8'd3; addr1 = 8'd4; wd0 = 8'h11; wd1 = 8'h22;
    for (int i = 0; i < 128; i++) preload(8'(i), 8'($urandom_range(1, 255)));
    preload(8'd7, 8'h00);
    checks++;
    if ({gnt0, gnt1, done0, done1, busy, memWrite} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000", {gnt0, gnt1, done0, done1, busy, memWrite});
    checks++;
    if ({rd0, rd1} !== 16'h0) $display("FAIL reset_rddata: got %h want 0000", {rd0, rd1});
    checks++;
    if ({memAddr, memWrData} !== 16'h0) $display("FAIL reset_memport: got %h want 0000", {memAddr, memWrData});
    if ({gnt0, gnt1, done0, done1, busy, memWrite} !== 6'b0 || {rd0, rd1, memAddr, memWrData} !== 32'h0) errs++;
    req0 = 1'b0; req1 = 1'b0; write0 = 1'b0; write1 = 1'b0;
    rstN = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin errs++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_read();
    logic other = 1'b0;
    preload(8'd5, 8'hA5);
    req0 = 1'b1; write0 = 1'b0; addr0 = 8'd5;
    step();
    other |= gnt1 | done1;
    checks++;
    if ({gnt0, busy, memWrite} !== 3'b110) begin errs++; $display("FAIL read_c1: gnt/busy/memWrite got %b want 110", {gnt0, busy, memWrite}); end
    checks++;
    if (memAddr !== 8'd5) begin errs++; $display("FAIL read_addr: got %0d want 5", memAddr); end
    req0 = 1'b0;
    step();
    other |= gnt1 | done1;
    checks++;
    if ({gnt0, done0, busy} !== 3'b001) begin errs++; $display("FAIL read_c2: gnt/done/busy got %b want 001", {gnt0, done0, busy}); end
    step();
    other |= gnt1 | done1;
    checks++;
    if ({done0, busy} !== 2'b10) begin errs++; $display("FAIL read_c3: done/busy got %b want 10", {done0, busy}); end
    checks++;
    if (rd0 !== 8'hA5) begin errs++; $display("FAIL read_data: got %h want a5", rd0); end
    step();
    other |= gnt1 | done1;
    checks++;
    if (done0 !== 1'b0 || rd0 !== 8'hA5) begin errs++; $display("FAIL read_hold: done=%b rd=%h want 0 a5", done0, rd0); end
    checks++;
    if (other !== 1'b0) begin errs++; $display("FAIL read_other_master: got %b want 0", other); end
  endtask

  task automatic test_write_readback();
    int nw = 0, nd = 0, badaddr = 0;
    logic [W-1:0] got = '0;
    req1 = 1'b1; write1 = 1'b1; addr1 = 8'd7; wd1 = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      step();
      if (memWrite) begin nw++; if (memAddr !== 8'd7) badaddr++; end
      if (gnt1) req1 = 1'b0;
      if (done1) nd++;
    end
    checks++;
    if (nw != 1 || badaddr != 0) begin errs++; $display("FAIL wr_pulse: cycles=%0d badaddr=%0d want 1 0", nw, badaddr); end
    checks++;
    if (mem[7] !== 8'h3C) begin errs++; $display("FAIL wr_mem: got %h want 3c", mem[7]); end
    checks++;
    if (nd != 1) begin errs++; $display("FAIL wr_done: got %0d want 1", nd); end
    nw = 0; nd = 0;
    req1 = 1'b1; write1 = 1'b0; addr1 = 8'd7;
    for (int i = 0; i < 4; i++) begin
      step();
      if (memWrite) nw++;
      if (gnt1) req1 = 1'b0;
      if (done1) begin nd++; got = rd1; end
    end
    checks++;
    if (nd != 1 || got !== 8'h3C) begin errs++; $display("FAIL rb_data: dones=%0d got %h want 1 3c", nd, got); end
    checks++;
    if (nw != 0) begin errs++; $display("FAIL rb_nowrite: got %0d want 0", nw); end
  endtask

  task automatic test_out_of_range();
    logic [W-1:0] snap [0:99];
    int nw = 0, nd = 0, diff = 0;
    logic [W-1:0] got = 8'hEE;
    for (int i = 0; i < 100; i++) snap[i] = mem[i];
    req0 = 1'b1; write0 = 1'b1; addr0 = 8'd120; wd0 = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      step();
      if (memWrite) nw++;
      if (gnt0) req0 = 1'b0;
      if (done0) nd++;
    end
    req0 = 1'b1; write0 = 1'b0; addr0 = 8'd120;
    for (int i = 0; i < 4; i++) begin
      step();
      if (memWrite) nw++;
      if (gnt0) req0 = 1'b0;
      if (done0) begin nd++; got = rd0; end
    end
    for (int i = 0; i < 100; i++) if (mem[i] !== snap[i]) diff++;
    checks++;
    if (nw != 0) begin errs++; $display("FAIL oor_nowrite: got %0d want 0", nw); end
    checks++;
    if (nd != 2) begin errs++; $display("FAIL oor_done: got %0d want 2", nd); end
    checks++;
    if (got !== 8'h00) begin errs++; $display("FAIL oor_read: got %h want 00", got); end
    checks++;
    if (diff != 0) begin errs++; $display("FAIL oor_mem: changed=%0d want 0", diff); end
  endtask

  task automatic test_reset_midop();
    logic [W-1:0] old9;
    int nd = 0, n0 = 0, n1 = 0;
    old9 = mem[9];
    req0 = 1'b1; write0 = 1'b1; addr0 = 8'd9; wd0 = ~old9;
    step();
    checks++;
    if (gnt0 !== 1'b1) begin errs++; $display("FAIL rmid_gnt: got %b want 1", gnt0); end
    req0 = 1'b0;
    rstN = 1'b0;
    #1;
    checks++;
    if (memWrite !== 1'b0) begin errs++; $display("FAIL rmid_memwrite: got %b want 0", memWrite); end
    step();
    nd += int'(done0) + int'(done1);
    checks++;
    if ({gnt0, gnt1, done0, done1, busy, memWrite, rd0, rd1, memAddr, memWrData} !== 38'h0) begin
      errs++; $display("FAIL rmid_zero: got %h want 0", {gnt0, gnt1, done0, done1, busy, memWrite, rd0, rd1, memAddr, memWrData});
    end
    rstN = 1'b1;
    for (int i = 0; i < 3; i++) begin step(); nd += int'(done0) + int'(done1); end
    checks++;
    if (nd != 0) begin errs++; $display("FAIL rmid_nodone: got %0d want 0", nd); end
    checks++;
    if (mem[9] !== old9) begin errs++; $display("FAIL rmid_mem: got %h want %h", mem[9], old9); end
    req0 = 1'b1; write0 = 1'b0; addr0 = 8'd1;
    req1 = 1'b1; write1 = 1'b0; addr1 = 8'd2;
    step();
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin errs++; $display("FAIL rmid_tie: gnt0/gnt1 got %b want 10", {gnt0, gnt1}); end
    req0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (gnt1) req1 = 1'b0;
      n0 += int'(done0); n1 += int'(done1);
    end
    checks++;
    if (n0 != 1 || n1 != 1) begin errs++; $display("FAIL rmid_after: done0=%0d done1=%0d want 1 1", n0, n1); end
  endtask

  task automatic test_late_request();
    logic [5:0] bz = '0;
    logic [W-1:0] exp4;
    exp4 = mem[4];
    req0 = 1'b1; write0 = 1'b0; addr0 = 8'd3;
    step(); bz[0] = busy;
    checks++;
    if (gnt0 !== 1'b1) begin errs++; $display("FAIL late_gnt0: got %b want 1", gnt0); end
    req0 = 1'b0;
    req1 = 1'b1; write1 = 1'b0; addr1 = 8'd4;
    step(); bz[1] = busy;
    checks++;
    if (gnt1 !== 1'b0) begin errs++; $display("FAIL late_c2_gnt1: got %b want 0", gnt1); end
    step(); bz[2] = busy;
    checks++;
    if ({done0, gnt1} !== 2'b10) begin errs++; $display("FAIL late_c3: done0/gnt1 got %b want 10", {done0, gnt1}); end
    step(); bz[3] = busy;
    checks++;
    if (gnt1 !== 1'b1) begin errs++; $display("FAIL late_gnt1: got %b want 1", gnt1); end
    req1 = 1'b0;
    step(); bz[4] = busy;
    step(); bz[5] = busy;
    checks++;
    if (done1 !== 1'b1 || rd1 !== exp4) begin errs++; $display("FAIL late_done1: done=%b rd=%h want 1 %h", done1, rd1, exp4); end
    checks++;
    if (bz !== 6'b011011) begin errs++; $display("FAIL late_busy: got %b want 011011", bz); end
  endtask

  task automatic test_contention();
    int g = 0, lastg = -100, cyc = 0;
    logic pend_own = 1'b0, pend_wr = 1'b0, raise0 = 1'b0, raise1 = 1'b0;
    logic [W-1:0] pend_exp = '0, d;
    logic [A-1:0] a;
    for (int i = 0; i < 256; i++) shadow[i] = mem[i];
    rstN = 1'b0; step(); rstN = 1'b1;
    req0 = 1'b1; write0 = 1'($urandom); addr0 = 8'($urandom_range(0, 127)); wd0 = 8'($urandom);
    req1 = 1'b1; write1 = 1'($urandom); addr1 = 8'($urandom_range(0, 127)); wd1 = 8'($urandom);
    while (cyc < 40) begin
      step(); cyc++;
      if (raise0) begin req0 = 1'b1; write0 = 1'($urandom); addr0 = 8'($urandom_range(0, 127)); wd0 = 8'($urandom); raise0 = 1'b0; end
      if (raise1) begin req1 = 1'b1; write1 = 1'($urandom); addr1 = 8'($urandom_range(0, 127)); wd1 = 8'($urandom); raise1 = 1'b0; end
      checks++;
      if (gnt0 && gnt1) begin errs++; $display("FAIL cont_double_gnt: cycle %0d", cyc); end
      if (gnt0 || gnt1) begin
        checks++;
        if (gnt1 !== g[0]) begin errs++; $display("FAIL cont_order: grant %0d got master %0d want %0d", g, gnt1, g[0]); end
        checks++;
        if (cyc != ((g == 0) ? 1 : lastg + 3)) begin errs++; $display("FAIL cont_spacing: cycle %0d want %0d", cyc, (g == 0) ? 1 : lastg + 3); end
        pend_own = gnt1;
        pend_wr  = gnt1 ? write1 : write0;
        a        = gnt1 ? addr1 : addr0;
        d        = gnt1 ? wd1 : wd0;
        pend_exp = (int'(a) < S) ? shadow[a] : '0;
        if (pend_wr && int'(a) < S) shadow[a] = d;
        lastg = cyc; g++;
        if (gnt1) begin req1 = 1'b0; raise1 = 1'b1; end
        else      begin req0 = 1'b0; raise0 = 1'b1; end
      end
      if (done0 || done1) begin
        checks++;
        if (done1 !== pend_own || cyc != lastg + 2) begin errs++; $display("FAIL cont_done: cycle %0d master %0d want cycle %0d master %0d", cyc, done1, lastg + 2, pend_own); end
        if (!pend_wr) begin
          checks++;
          if ((pend_own ? rd1 : rd0) !== pend_exp) begin errs++; $display("FAIL cont_data: master %0d got %h want %h", pend_own, pend_own ? rd1 : rd0, pend_exp); end
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (g != 14) begin errs++; $display("FAIL cont_count: got %0d grants want 14", g); end
  endtask

  task automatic test_random();
    logic m_idle = 1'b1, m_last = 1'b1, own = 1'b0, wr = 1'b0, emw;
    logic p0, p1, cw0, cw1, eg0, eg1, ed0, ed1;
    logic [A-1:0] ca0, ca1, a = '0;
    logic [W-1:0] cd0, cd1, exp_rd = '0, m_rd0 = '0, m_rd1 = '0;
    int t_done = -1;
    for (int i = 0; i < 256; i++) shadow[i] = mem[i];
    req0 = 1'b0; req1 = 1'b0;
    rstN = 1'b0; step(); rstN = 1'b1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      p0 = req0; p1 = req1; cw0 = write0; cw1 = write1;
      ca0 = addr0; ca1 = addr1; cd0 = wd0; cd1 = wd1;
      step();
      eg0 = 1'b0; eg1 = 1'b0; ed0 = 1'b0; ed1 = 1'b0; emw = 1'b0;
      if (m_idle && (p0 || p1)) begin
        own    = (p0 && p1) ? ~m_last : p1;
        m_last = own; m_idle = 1'b0; t_done = cyc + 2;
        wr     = own ? cw1 : cw0;
        a      = own ? ca1 : ca0;
        exp_rd = (int'(a) < S) ? shadow[a] : '0;
        emw    = wr && (int'(a) < S);
        if (emw) shadow[a] = own ? cd1 : cd0;
        eg0 = !own; eg1 = own;
      end
      if (cyc == t_done) begin
        ed0 = !own; ed1 = own; m_idle = 1'b1;
        if (!wr) begin
          if (own) m_rd1 = exp_rd;
          else     m_rd0 = exp_rd;
        end
      end
      checks++;
      if ({gnt0, gnt1, done0, done1, busy, memWrite} !== {eg0, eg1, ed0, ed1, !m_idle, emw}) begin
        errs++; $display("FAIL rnd_ctrl: cycle %0d got %b want %b", cyc, {gnt0, gnt1, done0, done1, busy, memWrite}, {eg0, eg1, ed0, ed1, !m_idle, emw});
      end
      checks++;
      if (rd0 !== m_rd0 || rd1 !== m_rd1) begin errs++; $display("FAIL rnd_rddata: cycle %0d got %h %h want %h %h", cyc, rd0, rd1, m_rd0, m_rd1); end
      if (eg0 || eg1) begin
        checks++;
        if (memAddr !== a) begin errs++; $display("FAIL rnd_addr: cycle %0d got %0d want %0d", cyc, memAddr, a); end
      end
      if (gnt0) req0 = 1'b0;
      else if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1'b1; write0 = 1'($urandom); addr0 = 8'($urandom_range(0, 127)); wd0 = 8'($urandom);
      end
      if (gnt1) req1 = 1'b0;
      else if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1'b1; write1 = 1'($urandom); addr1 = 8'($urandom_range(0, 127)); wd1 = 8'($urandom);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (busy !== 1'b0) begin errs++; $display("FAIL rnd_drain: busy got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_readback();
    test_out_of_range();
    test_reset_midop();
    test_late_request();
    test_contention();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-requester round-robin arbiter and sequencer for the team's single-port synchronous `Memory` (one shared `write`/`addr`/`wrData` port, registered `rdData`). It accepts read/write commands from two independent masters, serialises them onto the memory port one at a time, and returns read data and a completion pulse to the granted master. It sits directly in front of `Memory`, and is the only driver of the memory's command inputs.

## Interface
- `width`, 8, data word width; must match the `Memory` instance.
- `addrSize`, 8, address width; must match the `Memory` instance.
- `size`, 100, number of valid memory words; addresses `>= size` are out of range.

- `clk`  in  1  single clock, rising edge.
- `rstN`  in  1  reset: synchronous, active-low.
- `req0` / `req1`  in  1  command request from master 0 / 1; held with its command until `gnt` is seen.
- `write0` / `write1`  in  1  1 = write, 0 = read.
- `addr0` / `addr1`  in  `addrSize`  command address.
- `wrData0` / `wrData1`  in  `width`  write data.
- `gnt0` / `gnt1`  out  1  one-cycle pulse: command accepted and latched.
- `done0` / `done1`  out  1  one-cycle pulse: command completed.
- `rdData0` / `rdData1`  out  `width`  read result; valid in the `done` cycle of a read, held until the next read completes for that master.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `memWrite`  out  1  drives `Memory.write`.
- `memAddr`  out  `addrSize`  drives `Memory.addr`.
- `memWrData`  out  `width`  drives `Memory.wrData`.
- `memRdData`  in  `width`  from `Memory.rdData`.

## Operation
- The FSM has three states:
  - IDLE: if any `req` is high at the clock edge, pick a winner, latch its `write`/`addr`/`wrData` into command registers plus a 1-bit `owner`, pulse that master's `gnt`, and go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: drive the memory from the command registers for exactly one cycle, then go to RESP.
  - RESP: `memRdData` is valid here. At the edge leaving RESP:
    - for a read, capture `memRdData` into `rdData[owner]`;
    - pulse `done[owner]`;
    - go to IDLE.
- Arbitration is round-robin with a `last` pointer.
  - When only one master requests, it wins.
  - When both request, the master that was not served last wins.
  - `last` updates on every grant. Its reset value is 1, so master 0 wins the first tie.
- `memWrite = (state == ACCESS) && cmdWrite && inRange`. It is 0 in every other state.
- `memAddr` and `memWrData` always equal the command registers.
- An out-of-range command (`addr >= size`) still follows the normal sequence and still gets `gnt` and `done`.
  - An out-of-range write is suppressed: `memWrite` stays 0.
  - An out-of-range read returns 0 instead of `memRdData`.
- Requests arriving in ACCESS or RESP are ignored until the FSM returns to IDLE. The master must keep `req` asserted.
- A master must drop `req` in the cycle after its `gnt`. If `req` is still high when the FSM next reaches IDLE, it is treated as a new command.
- Reset (`rstN` = 0 at a clock edge) in any state:
  - state goes to IDLE and `last` goes to 1;
  - `gnt*`, `done*`, `busy` and `memWrite` go to 0;
  - `rdData*`, `memAddr` and `memWrData` go to 0;
  - the in-flight command is abandoned with no `done`, and no memory write occurs after reset.

## Timing
- A request sampled at edge 1 produces:
  - `gnt` high in cycle 1, with the FSM in ACCESS and the memory driven;
  - the memory acting at edge 2;
  - the FSM in RESP in cycle 2;
  - `done` and `rdData` valid in cycle 3, with the FSM back in IDLE.
- Request-to-done latency is 3 cycles. Maximum throughput is one command per 3 cycles.
- With both masters continuously requesting, grants alternate with a 3-cycle spacing: 0, 1, 0, 1, …
- `gnt`, `done`, `rdData` and `busy` are registered outputs.
- `memWrite` is decoded from registered state only, so it is glitch-free.
- `busy` is high in ACCESS and RESP, i.e. the cycles in which `gnt` or RESP is active.

## Structure
- Shared package `memory_arbiter_pkg` holds:
  - the state enum (IDLE, ACCESS, RESP);
  - the owner encoding constants (`OWNER0 = 0`, `OWNER1 = 1`).
- Sub-module `rr_pick2` is the purely combinational 2-way round-robin chooser.
  - Inputs: `req0`, `req1`, `last`.
  - Outputs: `valid`, `winner`.
- All registers, muxes and the range check live in the top module.

## Test plan
- Reset then single read: preload `Mem[5] = 8'hA5`; `req0 = 1`, `write0 = 0`, `addr0 = 5` → `gnt0` in cycle 1, `done0` in cycle 3, `rdData0 = 8'hA5`, `gnt1`/`done1` never pulse.
- Write then read back: master 1 writes `8'h3C` to addr 7, then reads addr 7 → `memWrite` high for exactly one cycle with `memAddr = 7`; the read returns `8'h3C`.
- Contention: both masters request from reset and keep re-requesting → grant order 0, 1, 0, 1 with 3-cycle spacing; each `done` goes to the correct master with its own data.
- Out of range: master 0 writes `8'hFF` to addr 120, then reads addr 120 → `memWrite` never asserts; `done0` pulses for both; the read returns 0; `Mem[0..99]` is unchanged.
- Reset mid-op: assert `rstN = 0` in the ACCESS cycle of a write → no `done`, all outputs 0 the next cycle, memory location unchanged, first tie after reset goes to master 0.
- Late request: `req1` rises during master 0's ACCESS → `gnt1` occurs in the cycle after `done0`; `busy` stays low only in the single IDLE cycle between the two commands.
